i2c_bus_conditioner: RTL and testbench
======================================

Name: i2c_bus_conditioner

Overview:
- Front-end stage directly upstream of the I2C target.
- Samples the raw SCL/SDA pad inputs into the clk_i domain.
- Rejects spikes on both lines and hands the target clean levels, single-cycle SCL edge strobes, START/STOP strobes, a bus-busy flag and a stuck-SCL timeout.
- The target's own start/stop and edge logic is replaced by these outputs. The SDA pad driver stays in the target.

Parameters:
- FILTER_LEN, 3: consecutive stable clk_i samples required before a filtered line changes. Range 1..15; 3 cycles is 111 ns at 27 MHz.
- TIMEOUT_W, 20: width of the SCL-low timeout counter.
- TIMEOUT_CYCLES, 675000: clk_i cycles of SCL low while busy that raise a timeout. This is 25 ms at 27 MHz. Must fit in TIMEOUT_W bits.

Ports:
- clk_i  input  1  system clock; the only clock.
- rst_i  input  1  asynchronous, active-high reset.
- scl_i  input  1  raw SCL pad level, asynchronous to clk_i.
- sda_i  input  1  raw SDA pad level, read back from the inout pad, asynchronous to clk_i.
- scl_o  output  1  filtered SCL level.
- sda_o  output  1  filtered SDA level.
- scl_rise_o  output  1  one-cycle pulse: scl_o went 0->1.
- scl_fall_o  output  1  one-cycle pulse: scl_o went 1->0.
- start_o  output  1  one-cycle pulse: START or repeated START detected.
- stop_o  output  1  one-cycle pulse: STOP detected.
- busy_o  output  1  high between a START and the following STOP or timeout.
- timeout_o  output  1  one-cycle pulse: SCL was held low past TIMEOUT_CYCLES while busy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Names are clk_i and rst_i. All state is cleared on rst_i assertion, with no dependence on clk_i.
- Reset values:
  - Sync flops, scl_o and sda_o: 1 (idle bus).
  - Filter counters and timeout counter: 0.
  - All pulse outputs and busy_o: 0.
- Synchroniser: each raw line passes through two flops before any logic uses it.
- Glitch filter, per line, identical and independent for SCL and SDA:
  - If the synced value differs from the filtered output, the line's counter increments. Otherwise the counter clears.
  - When the counter reaches FILTER_LEN-1 while the values still differ, the filtered output takes the synced value and the counter clears.
  - Latency from a raw level change to the filtered output is exactly 2 + FILTER_LEN clk_i cycles.
  - A pulse shorter than FILTER_LEN samples produces no change and no strobes.
- Edge strobes: scl_rise_o and scl_fall_o are registered. They assert in the same cycle scl_o first shows its new value, for exactly one cycle.
- START: sda_o commits 1->0 while scl_o is 1 and SCL does not commit in that same cycle. start_o pulses in the cycle sda_o first reads 0.
- STOP: sda_o commits 0->1 under the same SCL conditions. stop_o pulses in the cycle sda_o first reads 1.
- Simultaneous SCL and SDA commits in one cycle: no start_o or stop_o. Only the SCL edge strobe is produced.
- busy_o state machine, states IDLE (busy_o=0) and BUSY (busy_o=1):
  - IDLE -> BUSY on START.
  - BUSY -> BUSY on a repeated START; start_o still pulses.
  - BUSY -> IDLE on STOP or timeout. busy_o drops the cycle after the stop_o or timeout_o pulse.
  - A STOP seen in IDLE pulses stop_o and stays in IDLE.
- Timeout counter:
  - Counts while busy_o=1 and scl_o=0.
  - Clears whenever scl_o=1 or busy_o=0.
  - On reaching TIMEOUT_CYCLES-1: timeout_o pulses for one cycle, the counter clears and busy_o clears. Counting does not restart until the next START.
  - Saturation or wrap is impossible by construction.
- Reset mid-transaction: busy_o drops immediately and the filtered lines return to 1.
  - After release, a raw line still held low propagates to scl_o/sda_o after 2+FILTER_LEN cycles.
  - If SDA is low with SCL high at that point, a start_o pulse is produced. This is intended, so the target resynchronises to a bus it joined mid-frame.
- No combinational path exists from any input to any output.

Test Plan:
- Clean START (FILTER_LEN=3): SCL=1, SDA 1->0 at cycle 10 -> sda_o=0 and start_o=1 at cycle 15 only; busy_o=1 from cycle 16.
- Glitch rejection: 2-cycle low spike on SCL while high -> scl_o stays 1, no scl_fall_o. Repeat with a 3-cycle spike -> scl_fall_o then scl_rise_o, each exactly one cycle.
- Byte-frame edges: START, 9 SCL clock pulses, STOP -> exactly 9 scl_rise_o and 9 scl_fall_o; 1 start_o, 1 stop_o; busy_o low after stop.
- Repeated START: SDA 1->0 while SCL high and busy -> start_o pulses, busy_o stays 1; no stop_o.
- Timeout (TIMEOUT_CYCLES=100): after START, hold SCL low -> timeout_o pulses 100 cycles after scl_o falls, busy_o then 0. A later STOP gives stop_o with busy_o remaining 0.
- Async reset mid-frame: assert rst_i for 1 cycle with SCL=1, SDA=0 held -> outputs idle immediately; start_o pulses 5 cycles after release, busy_o=1.

Source files
------------

// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner: front end for the I2C target. Brings the raw SCL/SDA
// pad levels into clk_i, rejects spikes, and produces clean levels, SCL edge
// strobes, START/STOP strobes, a bus-busy flag and a stuck-SCL timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction open; busy_o = 0
// ST_BUSY | between a START and the following STOP or timeout; busy_o = 1

module i2c_bus_conditioner #(
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = 675000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam logic [3:0]           FLT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_q, scl_d, sda_q, sda_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic scl_commit, sda_commit;
  logic rise_q, rise_d, fall_q, fall_d;
  logic start_q, start_d, stop_q, stop_d;
  logic timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  state_t state_q;

  // Two-flop synchronisers; idle bus level is 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

  // Glitch filters: a line commits after FILTER_LEN consecutive differing
  // samples. Strobes are decided here so they line up with the committed level.
  always_comb begin
    scl_commit = (scl_s2_q != scl_q) && (scl_cnt_q == FLT_LAST);
    sda_commit = (sda_s2_q != sda_q) && (sda_cnt_q == FLT_LAST);

    scl_cnt_d  = ((scl_s2_q != scl_q) && !scl_commit) ? scl_cnt_q + 4'd1 : 4'd0;
    sda_cnt_d  = ((sda_s2_q != sda_q) && !sda_commit) ? sda_cnt_q + 4'd1 : 4'd0;

    scl_d      = scl_commit ? scl_s2_q : scl_q;
    sda_d      = sda_commit ? sda_s2_q : sda_q;

    rise_d     = scl_commit &&  scl_s2_q;
    fall_d     = scl_commit && !scl_s2_q;

    // SDA moving while SCL is steadily high; a simultaneous SCL commit is
    // treated as an ordinary clock edge, not a bus condition.
    start_d    = sda_commit && !sda_s2_q && scl_q && !scl_commit;
    stop_d     = sda_commit &&  sda_s2_q && scl_q && !scl_commit;
  end

  // Timeout counter runs only while busy with SCL low; once it fires it holds
  // at zero until busy drops, so it cannot re-arm before the next START.
  always_comb begin
    timeout_d = 1'b0;
    tcnt_d    = '0;
    if ((state_q == ST_BUSY) && !scl_q && !timeout_q) begin
      if (tcnt_q == TO_LAST) begin
        timeout_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TIMEOUT_W'(1);
      end
    end
  end

  // Filter state, filtered levels and registered strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // Bus-busy FSM follows the registered strobes, so busy_o moves one cycle
  // after start_o / stop_o / timeout_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_q) state_q <= ST_BUSY;
        ST_BUSY: begin
          if (start_q)                  state_q <= ST_BUSY;
          else if (stop_q || timeout_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign scl_o      = scl_q;
  assign sda_o      = sda_q;
  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign timeout_o  = timeout_q;
  assign busy_o     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed bench for i2c_bus_conditioner. Expected strobes (kind + cycle) are
// queued as stimulus is driven and matched by a negedge monitor.

module tb_i2c_bus_conditioner;

  localparam int FL  = 3;
  localparam int TO  = 100;
  localparam int LAT = 2 + FL;

  localparam int K_RISE = 0, K_FALL = 1, K_START = 2, K_STOP = 3, K_TOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;

  i2c_bus_conditioner #(
    .FILTER_LEN    (FL),
    .TIMEOUT_W     (20),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .scl_rise_o(scl_rise_o),
    .scl_fall_o(scl_fall_o),
    .start_o   (start_o),
    .stop_o    (stop_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0;
  logic [4:0] pulses;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t x;
    x.kind = kind;
    x.cyc  = at;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      pulses = {timeout_o, stop_o, start_o, scl_fall_o, scl_rise_o};
      for (int k = 0; k < 5; k++) begin
        if (pulses[k]) begin
          case (k)
            K_RISE:  n_rise++;
            K_FALL:  n_fall++;
            K_START: n_start++;
            K_STOP:  n_stop++;
            default: ;
          endcase
          if (sb.size() == 0) begin
            chk("unexpected_pulses", 32'(pulses), 0);
          end else begin
            e = sb.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int t, r0, f0, s0, st0;

    // Reset state
    step(2);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_pulses", {timeout_o, stop_o, start_o, scl_fall_o, scl_rise_o}, 0);
    rst = 1'b0;
    step(3);

    // 2-cycle SCL spike is rejected
    scl = 1'b0;
    step(2);
    scl = 1'b1;
    step(8);
    chk("spike2_scl_o", scl_o, 1);
    chk("spike2_nfall", n_fall, 0);

    // 3-cycle SCL spike passes: one fall then one rise
    scl = 1'b0;
    expect_ev(K_FALL, cyc + LAT);
    step(3);
    scl = 1'b1;
    expect_ev(K_RISE, cyc + LAT);
    step(8);
    chk("spike3_nfall", n_fall, 1);
    chk("spike3_nrise", n_rise, 1);
    chk("spike3_scl_o", scl_o, 1);

    // Clean START
    t = cyc;
    sda = 1'b0;
    expect_ev(K_START, t + LAT);
    step(LAT - 1);
    chk("start_sda_before", sda_o, 1);
    chk("start_busy_before", busy_o, 0);
    step(1);
    chk("start_sda_o", sda_o, 0);
    chk("start_pulse", start_o, 1);
    step(1);
    chk("start_pulse_one_cycle", start_o, 0);
    chk("start_busy_after", busy_o, 1);
    step(4);

    // Byte frame: 9 SCL pulses (last bit 0 as ACK), then STOP
    r0 = n_rise;
    f0 = n_fall;
    for (int i = 0; i < 9; i++) begin
      scl = 1'b0;
      expect_ev(K_FALL, cyc + LAT);
      step(6);
      sda = (i == 8) ? 1'b0 : 1'($urandom_range(0, 1));
      step(6);
      scl = 1'b1;
      expect_ev(K_RISE, cyc + LAT);
      step(8);
    end
    chk("frame_busy", busy_o, 1);
    t = cyc;
    sda = 1'b1;
    expect_ev(K_STOP, t + LAT);
    step(LAT);
    chk("stop_pulse", stop_o, 1);
    chk("stop_busy_same_cycle", busy_o, 1);
    step(1);
    chk("stop_busy_after", busy_o, 0);
    chk("frame_nrise", n_rise - r0, 9);
    chk("frame_nfall", n_fall - f0, 9);
    step(4);

    // Repeated START
    s0  = n_stop;
    st0 = n_start;
    sda = 1'b0;
    expect_ev(K_START, cyc + LAT);
    step(8);
    chk("rs_busy_first", busy_o, 1);
    scl = 1'b0;
    expect_ev(K_FALL, cyc + LAT);
    step(6);
    sda = 1'b1;
    step(6);
    scl = 1'b1;
    expect_ev(K_RISE, cyc + LAT);
    step(8);
    sda = 1'b0;
    expect_ev(K_START, cyc + LAT);
    step(LAT);
    chk("rs_start_pulse", start_o, 1);
    step(1);
    chk("rs_busy_kept", busy_o, 1);
    chk("rs_no_stop", n_stop, s0);
    chk("rs_nstart", n_start - st0, 2);
    step(4);

    // Timeout: SCL held low while busy
    t = cyc;
    scl = 1'b0;
    expect_ev(K_FALL, t + LAT);
    expect_ev(K_TOUT, t + LAT + TO);
    step(LAT + TO - 1);
    chk("to_not_yet", timeout_o, 0);
    chk("to_busy_before", busy_o, 1);
    step(1);
    chk("to_pulse", timeout_o, 1);
    chk("to_busy_same_cycle", busy_o, 1);
    step(1);
    chk("to_busy_after", busy_o, 0);
    chk("to_pulse_one_cycle", timeout_o, 0);
    step(5);
    scl = 1'b1;
    expect_ev(K_RISE, cyc + LAT);
    step(8);
    sda = 1'b1;
    expect_ev(K_STOP, cyc + LAT);
    step(LAT);
    chk("to_late_stop", stop_o, 1);
    chk("to_late_stop_busy", busy_o, 0);
    step(3);
    chk("to_idle_kept", busy_o, 0);

    // Asynchronous reset mid-frame with SCL=1, SDA=0 held
    sda = 1'b0;
    expect_ev(K_START, cyc + LAT);
    step(8);
    chk("ar_busy_before", busy_o, 1);
    chk("ar_sda_before", sda_o, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_busy_async", busy_o, 0);
    chk("ar_sda_async", sda_o, 1);
    chk("ar_scl_async", scl_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = cyc;
    expect_ev(K_START, t + LAT);
    step(LAT);
    chk("ar_start_pulse", start_o, 1);
    chk("ar_sda_o", sda_o, 0);
    step(1);
    chk("ar_busy_after", busy_o, 1);

    step(10);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
